// File: rtl/mem_miss_arbiter_pkg.sv
// Shared types for the miss arbiter: memory request payload, FSM states and cache ids.
package mem_miss_arbiter_pkg;

    localparam int LINE_W = 128;
    localparam int THR_W  = 2;
    localparam int ADDR_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
        logic              is_store;
        logic [THR_W-1:0]  thread_id;
    } mem_req_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } arb_state_t;

    localparam logic CACHE_ID_I = 1'b0;
    localparam logic CACHE_ID_D = 1'b1;

endpackage

// File: rtl/mem_miss_arbiter_req_queue.sv
// Per-source miss request FIFO; pushes while full are dropped, the head is read combinationally.
module mem_miss_arbiter_req_queue
    import mem_miss_arbiter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             not_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push   = push && !full;
    assign do_pop    = pop && not_empty;
    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign not_empty = (wr_ptr != rd_ptr);
    assign rd_data   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/mem_miss_arbiter.sv
// Shares one memory port between I$ and D$ misses: D$ priority with I$ anti-starvation,
// one request in flight, and a timeout that turns a lost response into a bus error.
module mem_miss_arbiter
    import mem_miss_arbiter_pkg::*;
#(
    parameter int QDEPTH       = 4,
    parameter int STARVE_LIMIT = 3,
    parameter int TIMEOUT      = 64
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              dcache_req_valid,
    input  mem_req_t          dcache_req_info,
    input  logic              icache_req_valid,
    input  mem_req_t          icache_req_info,
    output logic              dcache_q_full,
    output logic              icache_q_full,
    output logic              overflow_err,
    output logic              mem_req_valid,
    output mem_req_t          mem_req_info,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [LINE_W-1:0] mem_rsp_data,
    input  logic              mem_rsp_bus_error,
    output logic              rsp_valid_miss,
    output logic [LINE_W-1:0] rsp_data_miss,
    output logic              rsp_cache_id,
    output logic [THR_W-1:0]  rsp_thread_id,
    output logic              rsp_bus_error,
    output logic              busy
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT);

    function automatic logic [SW-1:0] starve_sat_inc(input logic [SW-1:0] v);
        return (v == SW'(STARVE_LIMIT)) ? v : v + 1'b1;
    endfunction

    arb_state_t        state_q, state_d;
    mem_req_t          d_head, i_head, req_p0;
    logic              d_ne, i_ne, d_pop, i_pop;
    logic              req_cid_p0;
    logic [SW-1:0]     starve_cnt_q;
    logic [TW-1:0]     tmo_cnt_q;
    logic              tmo_expired;
    logic              vld_p1;
    logic [LINE_W-1:0] rsp_data_p1;
    logic              rsp_cid_p1;
    logic [THR_W-1:0]  rsp_tid_p1;
    logic              rsp_berr_p1;
    logic              overflow_q;

    mem_miss_arbiter_req_queue #(.WIDTH($bits(mem_req_t)), .DEPTH(QDEPTH)) u_dq (
        .clk_i     (clk_i),
        .rst_n     (rst_n),
        .push      (dcache_req_valid),
        .wr_data   (dcache_req_info),
        .pop       (d_pop),
        .rd_data   (d_head),
        .full      (dcache_q_full),
        .not_empty (d_ne)
    );

    mem_miss_arbiter_req_queue #(.WIDTH($bits(mem_req_t)), .DEPTH(QDEPTH)) u_iq (
        .clk_i     (clk_i),
        .rst_n     (rst_n),
        .push      (icache_req_valid),
        .wr_data   (icache_req_info),
        .pop       (i_pop),
        .rd_data   (i_head),
        .full      (icache_q_full),
        .not_empty (i_ne)
    );

    assign tmo_expired = (tmo_cnt_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        d_pop   = 1'b0;
        i_pop   = 1'b0;
        case (state_q)
            IDLE: begin
                // D$ wins unless I$ has already been passed over STARVE_LIMIT times.
                if (d_ne && !(i_ne && starve_cnt_q == SW'(STARVE_LIMIT))) begin
                    d_pop   = 1'b1;
                    state_d = REQ;
                end else if (i_ne) begin
                    i_pop   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) state_d = WAIT_RSP;
            end
            WAIT_RSP: begin
                if (mem_rsp_valid || tmo_expired) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            tmo_cnt_q    <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((dcache_req_valid && dcache_q_full) || (icache_req_valid && icache_q_full))
                overflow_q <= 1'b1;
            if (i_pop || !i_ne)
                starve_cnt_q <= '0;
            else if (d_pop)
                starve_cnt_q <= starve_sat_inc(starve_cnt_q);
            if (state_q == REQ && mem_req_ready)
                tmo_cnt_q <= '0;
            else if (state_q == WAIT_RSP)
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    // Stage p0: granted request held for the memory port.
    always_ff @(posedge clk_i) begin
        if (d_pop) begin
            req_p0     <= d_head;
            req_cid_p0 <= CACHE_ID_D;
        end else if (i_pop) begin
            req_p0     <= i_head;
            req_cid_p0 <= CACHE_ID_I;
        end
    end

    // Stage p1: one-cycle response pulse; a same-cycle response beats the timeout.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            rsp_data_p1 <= '0;
            rsp_cid_p1  <= 1'b0;
            rsp_tid_p1  <= '0;
            rsp_berr_p1 <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            if (state_q == WAIT_RSP && (mem_rsp_valid || tmo_expired)) begin
                vld_p1      <= 1'b1;
                rsp_cid_p1  <= req_cid_p0;
                rsp_tid_p1  <= req_p0.thread_id;
                rsp_data_p1 <= mem_rsp_valid ? mem_rsp_data : '0;
                rsp_berr_p1 <= mem_rsp_valid ? mem_rsp_bus_error : 1'b1;
            end
        end
    end

    assign mem_req_valid  = (state_q == REQ);
    assign mem_req_info   = mem_req_valid ? req_p0 : '0;
    assign busy           = (state_q != IDLE);
    assign overflow_err   = overflow_q;
    assign rsp_valid_miss = vld_p1;
    assign rsp_data_miss  = rsp_data_p1;
    assign rsp_cache_id   = rsp_cid_p1;
    assign rsp_thread_id  = rsp_tid_p1;
    assign rsp_bus_error  = rsp_berr_p1;

endmodule

// File: tb/tb_mem_miss_arbiter.sv
// Directed scoreboard bench for mem_miss_arbiter with a simple delayed-response memory model.
`timescale 1ns/1ps
module tb_mem_miss_arbiter;
    import mem_miss_arbiter_pkg::*;

    typedef logic [LINE_W-1:0] vec_t;
    typedef struct {
        logic             cid;
        logic [THR_W-1:0] tid;
        vec_t             data;
        logic             berr;
    } exp_t;

    logic              clk_i = 1'b0;
    logic              rst_n = 1'b0;
    logic              dcache_req_valid, icache_req_valid;
    mem_req_t          dcache_req_info, icache_req_info;
    logic              dcache_q_full, icache_q_full, overflow_err;
    logic              mem_req_valid, mem_req_ready;
    mem_req_t          mem_req_info;
    logic              mem_rsp_valid, mem_rsp_bus_error;
    vec_t              mem_rsp_data;
    logic              rsp_valid_miss, rsp_cache_id, rsp_bus_error, busy;
    vec_t              rsp_data_miss;
    logic [THR_W-1:0]  rsp_thread_id;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   rsp_delay = 5;
    logic mem_berr = 1'b0;

    always #5 clk_i = ~clk_i;

    mem_miss_arbiter #(.QDEPTH(4), .STARVE_LIMIT(3), .TIMEOUT(64)) dut (
        .clk_i             (clk_i),
        .rst_n             (rst_n),
        .dcache_req_valid  (dcache_req_valid),
        .dcache_req_info   (dcache_req_info),
        .icache_req_valid  (icache_req_valid),
        .icache_req_info   (icache_req_info),
        .dcache_q_full     (dcache_q_full),
        .icache_q_full     (icache_q_full),
        .overflow_err      (overflow_err),
        .mem_req_valid     (mem_req_valid),
        .mem_req_info      (mem_req_info),
        .mem_req_ready     (mem_req_ready),
        .mem_rsp_valid     (mem_rsp_valid),
        .mem_rsp_data      (mem_rsp_data),
        .mem_rsp_bus_error (mem_rsp_bus_error),
        .rsp_valid_miss    (rsp_valid_miss),
        .rsp_data_miss     (rsp_data_miss),
        .rsp_cache_id      (rsp_cache_id),
        .rsp_thread_id     (rsp_thread_id),
        .rsp_bus_error     (rsp_bus_error),
        .busy              (busy)
    );

    function automatic vec_t line_of(input logic [31:0] a);
        return {a ^ 32'hA5A5_0000, ~a, a + 32'h1111, a};
    endfunction

    function automatic mem_req_t mk(input logic [31:0] a, input logic [THR_W-1:0] t);
        mem_req_t r;
        r.addr      = a;
        r.data      = ~line_of(a);
        r.is_store  = a[4];
        r.thread_id = t;
        return r;
    endfunction

    function automatic exp_t mk_exp(input logic c, input logic [THR_W-1:0] t,
                                    input vec_t d, input logic b);
        exp_t e;
        e.cid = c; e.tid = t; e.data = d; e.berr = b;
        return e;
    endfunction

    task automatic chk(input string tag, input vec_t obs, input vec_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i); #1;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!mem_req_valid && n < 50) begin step(); n++; end
        chk(tag, vec_t'(mem_req_valid), vec_t'(1));
    endtask

    task automatic drain(input string tag, input int maxc);
        int n = 0;
        while (sb.size() != 0 && n < maxc) begin step(); n++; end
        chk(tag, vec_t'(sb.size()), vec_t'(0));
        step(); step();
    endtask

    // Memory model: accepts on valid&ready, answers rsp_delay cycles later.
    initial begin : mem_model
        int          cnt;
        logic        pending;
        logic [31:0] paddr;
        pending = 1'b0; cnt = 0; paddr = '0;
        mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_bus_error = 1'b0;
        forever begin
            @(posedge clk_i); #2;
            mem_rsp_valid     = 1'b0;
            mem_rsp_bus_error = 1'b0;
            if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    mem_rsp_valid     = 1'b1;
                    mem_rsp_data      = line_of(paddr);
                    mem_rsp_bus_error = mem_berr;
                    pending           = 1'b0;
                end
            end else if (mem_req_valid && mem_req_ready) begin
                pending = 1'b1;
                cnt     = rsp_delay;
                paddr   = mem_req_info.addr;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_i); #1;
            if (rsp_valid_miss) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", vec_t'(1), vec_t'(0));
                end else begin
                    e = sb.pop_front();
                    chk("rsp_cache_id", vec_t'(rsp_cache_id), vec_t'(e.cid));
                    chk("rsp_thread_id", vec_t'(rsp_thread_id), vec_t'(e.tid));
                    chk("rsp_data", rsp_data_miss, e.data);
                    chk("rsp_bus_error", vec_t'(rsp_bus_error), vec_t'(e.berr));
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int   seen;
        dcache_req_valid = 1'b0; icache_req_valid = 1'b0;
        dcache_req_info  = '0;   icache_req_info  = '0;
        mem_req_ready    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_flags", vec_t'({dcache_q_full, icache_q_full, overflow_err, mem_req_valid,
                                   rsp_valid_miss, rsp_cache_id, rsp_bus_error, busy}), vec_t'(0));
        chk("reset_req_info", vec_t'(mem_req_info == '0), vec_t'(1));
        chk("reset_rsp_data", rsp_data_miss, vec_t'(0));
        rst_n = 1'b1;
        step();

        // 1: single D$ load at 0x40, response 5 cycles after acceptance
        rsp_delay = 5;
        sb.push_back(mk_exp(CACHE_ID_D, 2'd0, line_of(32'h40), 1'b0));
        dcache_req_valid = 1'b1; dcache_req_info = mk(32'h40, 2'd0);
        step();
        dcache_req_valid = 1'b0;
        chk("t1_no_req_at_grant", vec_t'(mem_req_valid), vec_t'(0));
        step();
        chk("t1_req_valid", vec_t'(mem_req_valid), vec_t'(1));
        chk("t1_req_addr", vec_t'(mem_req_info.addr), vec_t'(32'h40));
        repeat (5) step();
        chk("t1_no_early_rsp", vec_t'(rsp_valid_miss), vec_t'(0));
        step();
        chk("t1_rsp_pulse", vec_t'(rsp_valid_miss), vec_t'(1));
        step();
        chk("t1_pulse_one_cycle", vec_t'(rsp_valid_miss), vec_t'(0));
        chk("t1_idle", vec_t'(busy), vec_t'(0));
        drain("t1_drain", 20);

        // 2: simultaneous D$ (thread 1) and I$ (thread 2): D$ first
        rsp_delay = 3;
        sb.push_back(mk_exp(CACHE_ID_D, 2'd1, line_of(32'h100), 1'b0));
        sb.push_back(mk_exp(CACHE_ID_I, 2'd2, line_of(32'h200), 1'b0));
        dcache_req_valid = 1'b1; dcache_req_info = mk(32'h100, 2'd1);
        icache_req_valid = 1'b1; icache_req_info = mk(32'h200, 2'd2);
        step();
        dcache_req_valid = 1'b0; icache_req_valid = 1'b0;
        drain("t2_drain", 100);

        // 3: D$ stream with one I$ pending; I$ must be the 4th grant
        rsp_delay = 2;
        for (int i = 0; i < 3; i++)
            sb.push_back(mk_exp(CACHE_ID_D, THR_W'(i), line_of(32'h1000 + 32'(i) * 16), 1'b0));
        sb.push_back(mk_exp(CACHE_ID_I, 2'd3, line_of(32'h2000), 1'b0));
        for (int i = 3; i < 8; i++)
            sb.push_back(mk_exp(CACHE_ID_D, THR_W'(i), line_of(32'h1000 + 32'(i) * 16), 1'b0));
        icache_req_valid = 1'b1; icache_req_info = mk(32'h2000, 2'd3);
        for (int i = 0; i < 8; i++) begin
            seen = 0;
            while (dcache_q_full && seen < 100) begin
                dcache_req_valid = 1'b0; icache_req_valid = 1'b0;
                step(); seen++;
            end
            dcache_req_valid = 1'b1;
            dcache_req_info  = mk(32'h1000 + 32'(i) * 16, THR_W'(i));
            step();
            icache_req_valid = 1'b0;
        end
        dcache_req_valid = 1'b0;
        drain("t3_drain", 300);
        chk("t3_no_overflow", vec_t'(overflow_err), vec_t'(0));

        // 4: memory stalled; 5 pushes into a 4-deep queue
        mem_req_ready = 1'b0;
        rsp_delay = 2;
        sb.push_back(mk_exp(CACHE_ID_D, 2'd0, line_of(32'h3000), 1'b0));
        dcache_req_valid = 1'b1; dcache_req_info = mk(32'h3000, 2'd0);
        step();
        dcache_req_valid = 1'b0;
        step();
        chk("t4_stalled_in_req", vec_t'(mem_req_valid), vec_t'(1));
        for (int i = 0; i < 4; i++) begin
            sb.push_back(mk_exp(CACHE_ID_D, THR_W'(i), line_of(32'h3100 + 32'(i) * 16), 1'b0));
            dcache_req_valid = 1'b1;
            dcache_req_info  = mk(32'h3100 + 32'(i) * 16, THR_W'(i));
            step();
        end
        chk("t4_full_after_4", vec_t'(dcache_q_full), vec_t'(1));
        chk("t4_no_overflow_yet", vec_t'(overflow_err), vec_t'(0));
        dcache_req_info = mk(32'h3F00, 2'd3);
        step();
        dcache_req_valid = 1'b0;
        chk("t4_overflow_set", vec_t'(overflow_err), vec_t'(1));
        chk("t4_still_full", vec_t'(dcache_q_full), vec_t'(1));
        mem_req_ready = 1'b1;
        drain("t4_drain", 200);
        chk("t4_not_full", vec_t'(dcache_q_full), vec_t'(0));
        chk("t4_overflow_sticky", vec_t'(overflow_err), vec_t'(1));

        // 5: memory answers after the timeout; late response ignored
        rsp_delay = 70;
        sb.push_back(mk_exp(CACHE_ID_D, 2'd1, vec_t'(0), 1'b1));
        dcache_req_valid = 1'b1; dcache_req_info = mk(32'h4000, 2'd1);
        step();
        dcache_req_valid = 1'b0;
        wait_req("t5_req_seen");
        repeat (64) step();
        chk("t5_no_rsp_before_tmo", vec_t'(rsp_valid_miss), vec_t'(1'b0));
        step();
        chk("t5_tmo_pulse", vec_t'(rsp_valid_miss), vec_t'(1));
        repeat (12) step();
        chk("t5_idle_after_late", vec_t'(busy), vec_t'(0));
        drain("t5_drain", 5);

        // bus error reported by memory on an I$ fetch
        rsp_delay = 2;
        mem_berr  = 1'b1;
        sb.push_back(mk_exp(CACHE_ID_I, 2'd2, line_of(32'h5000), 1'b1));
        icache_req_valid = 1'b1; icache_req_info = mk(32'h5000, 2'd2);
        step();
        icache_req_valid = 1'b0;
        drain("berr_drain", 50);
        mem_berr = 1'b0;

        // 6: reset while waiting with two entries in each queue
        rsp_delay = 40;
        dcache_req_valid = 1'b1; dcache_req_info = mk(32'h6000, 2'd0);
        step();
        dcache_req_valid = 1'b0;
        wait_req("t6_req_seen");
        step(); step();
        for (int i = 0; i < 2; i++) begin
            dcache_req_valid = 1'b1; dcache_req_info = mk(32'h6100 + 32'(i) * 16, 2'd1);
            icache_req_valid = 1'b1; icache_req_info = mk(32'h6200 + 32'(i) * 16, 2'd2);
            step();
        end
        dcache_req_valid = 1'b0; icache_req_valid = 1'b0;
        chk("t6_busy_before_reset", vec_t'(busy), vec_t'(1));
        #3 rst_n = 1'b0;
        #1;
        chk("t6_reset_flags", vec_t'({dcache_q_full, icache_q_full, overflow_err, mem_req_valid,
                                      rsp_valid_miss, rsp_bus_error, busy}), vec_t'(0));
        chk("t6_reset_req_info", vec_t'(mem_req_info == '0), vec_t'(1));
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (mem_req_valid || busy || rsp_valid_miss) seen = 1;
        end
        chk("t6_quiet_after_reset", vec_t'(seen), vec_t'(0));
        chk("t6_sb_empty", vec_t'(sb.size()), vec_t'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
